// File: rtl/axi_fifo_flex_pkg.sv
// Shared definitions for axi_fifo_flex: read-side FSM encoding, status width
// and the parameter legality check used at elaboration.
package axi_fifo_flex_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_VALID    = 2'd2
  } rd_state_e;

  function automatic bit fifo_params_ok(input int width, input int size,
                                        input int pkt_mode, input int af_thresh,
                                        input int ae_thresh);
    return (width >= 1) && (width <= 1024) &&
           (size >= 2) && (size <= 15) &&
           (pkt_mode == 0 || pkt_mode == 1) &&
           (af_thresh >= 0) && (af_thresh <= (1 << size)) &&
           (ae_thresh >= 0) && (ae_thresh <= (1 << size));
  endfunction

endpackage

// File: rtl/ram_2port.sv
// Simple dual-port block RAM: one write port, one read port with a
// registered (1-cycle) read that holds its value while re is low.
module ram_2port #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [1 << AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_fifo_flex.sv
// AXI-Stream FIFO with block-RAM storage and a first-word-fall-through output
// register; optional store-and-forward on tlast with oversize cut-through.
module axi_fifo_flex
  import axi_fifo_flex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 9,
  parameter int PKT_MODE  = 0,
  parameter int AF_THRESH = (1 << SIZE) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [WIDTH-1:0]  o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [STAT_W-1:0] space,
  output logic [STAT_W-1:0] occupied,
  output logic [STAT_W-1:0] pkt_count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int              DEPTH   = 1 << SIZE;
  localparam logic [SIZE:0]   DepthV  = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0]   AfThr   = (SIZE+1)'(AF_THRESH);
  localparam logic [SIZE:0]   AeThr   = (SIZE+1)'(AE_THRESH);
  localparam bit              PktMode = (PKT_MODE != 0);

  if (!fifo_params_ok(WIDTH, SIZE, PKT_MODE, AF_THRESH, AE_THRESH)) begin : g_param_check
    $error("axi_fifo_flex: parameter out of range");
  end

  rd_state_e       state_q, state_d;
  logic [SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SIZE:0]   occ_q, occ_d, ram_cnt_q, ram_cnt_d, pkts_q, pkts_d;
  logic            started_q, started_d, af_q, af_d, ae_q, ae_d;
  logic            wr_en, rd_en, wr_last, rd_last, forced, started, rel_ok, fetch;
  logic [WIDTH:0]  ram_dout;

  assign i_tready     = ~occ_q[SIZE];
  assign o_tvalid     = (state_q == ST_VALID);
  assign o_tdata      = ram_dout[WIDTH-1:0];
  assign o_tlast      = ram_dout[WIDTH];
  assign occupied     = STAT_W'(occ_q);
  assign space        = STAT_W'(DepthV - occ_q);
  assign pkt_count    = STAT_W'(pkts_q);
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

  // The RAM read register doubles as the output register, so a fetch is only
  // issued when the output is empty-bound (PREFETCH) or being consumed (VALID).
  always_comb begin
    wr_en   = i_tvalid & i_tready;
    rd_en   = o_tvalid & o_tready;
    wr_last = wr_en & i_tlast;
    rd_last = rd_en & o_tlast;
    forced  = (occ_q == DepthV) && (pkts_q == '0);
    started = rd_en ? ~o_tlast : started_q;
    rel_ok  = !PktMode || started || forced || wr_last ||
              ((pkts_q - (SIZE+1)'(rd_last)) != '0);
    fetch   = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (((ram_cnt_q != '0) || wr_en) && rel_ok) state_d = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        fetch   = 1'b1;
        state_d = ST_VALID;
      end
      ST_VALID: begin
        if (rd_en) begin
          if ((ram_cnt_q != '0) && rel_ok) fetch = 1'b1;
          else state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (clear) begin
      fetch   = 1'b0;
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + SIZE'(wr_en);
    rd_ptr_d  = rd_ptr_q + SIZE'(fetch);
    ram_cnt_d = ram_cnt_q + (SIZE+1)'(wr_en) - (SIZE+1)'(fetch);
    occ_d     = occ_q + (SIZE+1)'(wr_en) - (SIZE+1)'(rd_en);
    pkts_d    = PktMode ? (pkts_q + (SIZE+1)'(wr_last) - (SIZE+1)'(rd_last)) : '0;
    started_d = PktMode & started;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      occ_d     = '0;
      pkts_d    = '0;
      started_d = 1'b0;
    end
    af_d = (occ_d >= AfThr);
    ae_d = (occ_d <= AeThr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      occ_q     <= '0;
      pkts_q    <= '0;
      started_q <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      occ_q     <= occ_d;
      pkts_q    <= pkts_d;
      started_q <= started_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
    end
  end

  ram_2port #(
    .DWIDTH(WIDTH + 1),
    .AWIDTH(SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata({i_tlast, i_tdata}),
    .re   (fetch),
    .raddr(rd_ptr_q),
    .rdata(ram_dout)
  );

endmodule
